vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480 @ 60 Hz VGA timing constants and the coordinate type
//               shared by the timing generator and the logo/sprite blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] vga_coord_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 25 MHz pixel strobe, pixel/line counters and registered
//               HS/VS/BLANK_N from a 50 MHz clock; frame_start on each wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_VISIBLE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACTIVE = V_VISIBLE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_en,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam vga_coord_t H_VIS_LAST   = vga_coord_t'(H_ACTIVE - 1);
    localparam vga_coord_t H_SYNC_FIRST = vga_coord_t'(H_ACTIVE + H_FRONT);
    localparam vga_coord_t H_SYNC_LAST  = vga_coord_t'(H_ACTIVE + H_FRONT + H_SYNC_W - 1);
    localparam vga_coord_t H_LAST       = vga_coord_t'(H_ACTIVE + H_FRONT + H_SYNC_W + H_BACK - 1);

    localparam vga_coord_t V_VIS_LAST   = vga_coord_t'(V_ACTIVE - 1);
    localparam vga_coord_t V_SYNC_FIRST = vga_coord_t'(V_ACTIVE + V_FRONT);
    localparam vga_coord_t V_SYNC_LAST  = vga_coord_t'(V_ACTIVE + V_FRONT + V_SYNC_W - 1);
    localparam vga_coord_t V_LAST       = vga_coord_t'(V_ACTIVE + V_FRONT + V_SYNC_W + V_BACK - 1);

    logic       r_phase;
    logic       r_vga_clk;
    vga_coord_t r_hc;
    vga_coord_t r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic       r_frame_start;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_frame_wrap;
    vga_coord_t w_hc_next;
    vga_coord_t w_vc_next;

    assign w_h_last     = (r_hc == H_LAST);
    assign w_v_last     = (r_vc == V_LAST);
    assign w_frame_wrap = r_phase && w_h_last && w_v_last;

    // Sync/blank are derived from the next counter values so the registered
    // outputs always describe the pixel currently shown on DrawX/DrawY.
    always_comb begin
        w_hc_next = r_hc;
        w_vc_next = r_vc;
        if (r_phase) begin
            if (w_h_last) begin
                w_hc_next = '0;
                w_vc_next = w_v_last ? '0 : r_vc + 10'd1;
            end else begin
                w_hc_next = r_hc + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_phase       <= 1'b0;
            r_vga_clk     <= 1'b0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_phase       <= ~r_phase;
            r_vga_clk     <= r_phase;
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_hs          <= !((w_hc_next >= H_SYNC_FIRST) && (w_hc_next <= H_SYNC_LAST));
            r_vs          <= !((w_vc_next >= V_SYNC_FIRST) && (w_vc_next <= V_SYNC_LAST));
            r_blank_n     <= (w_hc_next <= H_VIS_LAST) && (w_vc_next <= V_VIS_LAST);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign pixel_en    = r_phase;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
